// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants, counter widths and
// the run-flag state type. Imported by the timing generator and painters.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned HPOS_W = 10;
    localparam int unsigned VPOS_W = 10;

    localparam logic SYNC_ACTIVE = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_t;

endpackage

// File: rtl/vga_timing_generator_if.sv
// vga_timing_generator_if: raster position, syncs and strobes produced by
// the timing generator (master) and consumed by painter stages (slave).
interface vga_timing_generator_if;
    import vga_timing_pkg::*;

    logic [HPOS_W-1:0] hpos;
    logic [VPOS_W-1:0] vpos;
    logic              hsync;
    logic              vsync;
    logic              display_on;
    logic              line_start;
    logic              frame_start;
    logic              pix_stb;

    modport master (
        output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, pix_stb
    );

    modport slave (
        input hpos, vpos, hsync, vsync, display_on, line_start, frame_start, pix_stb
    );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Enabled position counter wrapping at
// TOTAL-1, combinational wrap/next-visible, and a sync output registered
// from the next-state position so it lines up with pos.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned W          = HPOS_W,
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned VISIBLE    = 640,
    parameter int unsigned SYNC_FIRST = 656,
    parameter int unsigned SYNC_LAST  = 751,
    parameter logic        SYNC_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         sync,
    output logic         next_visible
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_END = W'(VISIBLE);
    localparam logic [W-1:0] S_FIRST = W'(SYNC_FIRST);
    localparam logic [W-1:0] S_LAST  = W'(SYNC_LAST);

    logic [W-1:0] pos_next;

    // Next position: explicit compare against TOTAL-1, no overflow reliance
    always_comb begin
        wrap     = en && (pos == LAST);
        pos_next = pos;
        if (wrap) begin
            pos_next = '0;
        end else if (en) begin
            pos_next = pos + 1'b1;
        end
        next_visible = (pos_next < VIS_END);
    end

    // Position and sync registers, sync decoded from the incoming position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos  <= '0;
            sync <= ~SYNC_LEVEL;
        end else begin
            pos  <= pos_next;
            sync <= (pos_next >= S_FIRST && pos_next <= S_LAST) ? SYNC_LEVEL : ~SYNC_LEVEL;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: 640x480@60 raster timing. Every output is
// registered from next-state counter values, so all of them describe the
// hpos/vpos presented in the same cycle.
// Optional macro VGA_CLKDIV2_EN: pix_stb on alternate clks, each position
// held two clks (for a 50 MHz clk).
module vga_timing_generator #(
    parameter int unsigned H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
    parameter logic        SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    vga_timing_generator_if.master        vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    vga_timing_pkg::run_state_t state;

    logic start;
    logic adv;
    logic h_wrap;
    logic v_wrap;
    logic h_next_visible;
    logic v_next_visible;
`ifdef VGA_CLKDIV2_EN
    logic phase;
`endif

    // Counter step condition: every RUN clk, or every other RUN clk when divided
    always_comb begin
        start = (state == vga_timing_pkg::IDLE);
`ifdef VGA_CLKDIV2_EN
        adv = !start && !phase;
`else
        adv = !start;
`endif
    end

    vga_axis_counter #(
        .W          (vga_timing_pkg::HPOS_W),
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_FIRST (H_VISIBLE + H_FRONT),
        .SYNC_LAST  (H_VISIBLE + H_FRONT + H_SYNC - 1),
        .SYNC_LEVEL (SYNC_ACTIVE)
    ) u_h (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (adv),
        .pos          (vga.hpos),
        .wrap         (h_wrap),
        .sync         (vga.hsync),
        .next_visible (h_next_visible)
    );

    vga_axis_counter #(
        .W          (vga_timing_pkg::VPOS_W),
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_FIRST (V_VISIBLE + V_FRONT),
        .SYNC_LAST  (V_VISIBLE + V_FRONT + V_SYNC - 1),
        .SYNC_LEVEL (SYNC_ACTIVE)
    ) u_v (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (h_wrap),
        .pos          (vga.vpos),
        .wrap         (v_wrap),
        .sync         (vga.vsync),
        .next_visible (v_next_visible)
    );

    // Run flag and registered strobes; a position is first presented either
    // on the IDLE->RUN edge or on the edge where its axis wrapped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= vga_timing_pkg::IDLE;
            vga.display_on  <= 1'b0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
`ifdef VGA_CLKDIV2_EN
            phase           <= 1'b0;
            vga.pix_stb     <= 1'b0;
`else
            vga.pix_stb     <= 1'b1;
`endif
        end else begin
            state           <= vga_timing_pkg::RUN;
            vga.display_on  <= h_next_visible && v_next_visible;
            vga.line_start  <= start || h_wrap;
            vga.frame_start <= start || v_wrap;
`ifdef VGA_CLKDIV2_EN
            phase           <= start ? 1'b1 : !phase;
            vga.pix_stb     <= start || adv;
`else
            vga.pix_stb     <= 1'b1;
`endif
        end
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Generates the VGA 640x480@60 raster: pixel/line counters, hsync/vsync, display-enable and frame/line strobes.
- Sits directly upstream of every painter stage: border, paddles, ball and score.
- Painters consume hpos and vpos[8:0] combinationally and are only sampled while display_on=1.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 1'b0, level driven on hsync/vsync while a pulse is active (0 = negative polarity)

Ports:
clk  input  1  system clock (25.175 MHz nominal, 50 MHz with VGA_CLKDIV2_EN)
rst_n  input  1  asynchronous active-low reset
hpos  output  10  pixel column, 0..H_TOTAL-1
vpos  output  10  line number, 0..V_TOTAL-1; painters use [8:0]
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
display_on  output  1  high when hpos<H_VISIBLE and vpos<V_VISIBLE
line_start  output  1  one-clk pulse when hpos==0 is first presented
frame_start  output  1  one-clk pulse when (hpos,vpos)==(0,0) is first presented
pix_stb  output  1  high on clk cycles in which the raster position advances

Behaviour:
- H_TOTAL = sum of the H_* parameters = 800. V_TOTAL = sum of the V_* parameters = 525. Both are localparams.
- Two states, IDLE and RUN, tracked by a 1-bit run flag.
- Reset (rst_n low, async): state=IDLE, hpos=0, vpos=0, hsync=vsync=~SYNC_ACTIVE, display_on=0, line_start=0, frame_start=0.
  - Without the macro, pix_stb=1 even in reset.
  - With the macro, pix_stb=0 in reset.
- IDLE->RUN on the first clk edge after rst_n rises.
  - Counters stay at (0,0).
  - All outputs decode (0,0): display_on=1, line_start=1, frame_start=1.
- RUN, on each edge with pix_stb=1:
  - hpos increments; at H_TOTAL-1 it wraps to 0.
  - vpos increments only on the hpos wrap; at V_TOTAL-1 (together with the hpos wrap) it wraps to 0.
- All outputs are registered. Each is decoded from the next-state counter values, so every output corresponds to the hpos/vpos presented in the same cycle (zero relative latency, no glitches).
- hsync = SYNC_ACTIVE for hpos in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751]; otherwise ~SYNC_ACTIVE.
- vsync = SYNC_ACTIVE for vpos in [490,491], over full lines; otherwise ~SYNC_ACTIVE.
- line_start and frame_start are high only for the first clk of the position, even when pix_stb holds the position longer.
- Counter arithmetic is 10-bit unsigned. The wrap compares against TOTAL-1, never relying on overflow.
- Reset mid-frame: all outputs return to their reset values immediately. The sequence restarts via IDLE.

Optional Feature:
- Macro: VGA_CLKDIV2_EN.
- Defined:
  - An internal toggle generates pix_stb on alternate clks.
  - pix_stb is first high on the IDLE->RUN edge; the toggle is cleared by reset.
  - Counters advance only when pix_stb=1, so each position is held 2 clks.
  - This allows a 50 MHz clk.
- Undefined: pix_stb is constant 1 and the counters advance every clk.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 porch/sync constants;
  - the H_TOTAL/V_TOTAL derivations;
  - HPOS_W=10 and VPOS_W=10 width constants.
- The painters import the same package.
- Sub-module vga_axis_counter: a generic counter with enable, TOTAL-1 wrap, wrap output, and registered sync/visible decode. Instantiated once for h (enable = pix_stb) and once for v (enable = h wrap).

Test Plan:
- Reset held 5 clks then released:
  - during reset: hpos=0, vpos=0, hsync=vsync=1, display_on=0;
  - first edge after release: display_on=1, frame_start=1, line_start=1, counters still 0.
- One full line from (0,0):
  - display_on falls as hpos goes 639->640;
  - hsync is 0 exactly for hpos 656..751 (96 clks);
  - hpos 799->0 increments vpos to 1, with line_start=1 for that one clk.
- One full frame:
  - vsync is 0 for exactly 2x800 clks at vpos 490..491;
  - display_on is high for exactly 640x480 = 307200 clks;
  - frame_start recurs every 420000 clks.
- Wrap corner (799,524) -> (0,0): frame_start=1 and line_start=1 in the same clk; vpos never shows 525.
- Reset asserted at (700,300), in the hsync pulse: hsync returns to 1 and the counters to 0 asynchronously, before the next clk edge.
- With VGA_CLKDIV2_EN: pix_stb alternates 1,0; each hpos is held 2 clks; line_start is 1 clk wide; a full line takes 1600 clks.
